operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 5, register-address width (32 registers).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, register data width.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never pending.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream issue handshake.
REQ-007 SHALL have ports in_src1, in_src2, in_dst (input, REG_WIDTH each): source and destination register numbers.
REQ-008 SHALL have port in_dst_en  input  1  issued instruction writes in_dst.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-010 SHALL have ports out_op1, out_op2 (output, DATA_WIDTH each), plus out_dst (output, REG_WIDTH) and out_dst_en (output, 1).
REQ-011 SHALL have ports wb_en (input, 1), wb_addr (input, REG_WIDTH) and wb_data (input, DATA_WIDTH): the write-back bus.
REQ-012 SHALL have ports rf_rd_addr1, rf_rd_addr2 (output, REG_WIDTH) and rf_stall (output, 1), driving the register file's registered-address read side.
REQ-013 SHALL have ports rf_rd_data1, rf_rd_data2 (input, DATA_WIDTH): register-file read data, valid the cycle after the address is captured.
REQ-014 SHALL have ports rf_wen, rf_wr_addr, rf_wr_data (output), combinational copies of wb_en, wb_addr and wb_data.

Function
REQ-015 SHALL be a one-stage pipeline: an accepted instruction occupies stage S2; out_valid = s2_valid.
- Latency: accept at edge N gives out_valid high in cycle N+1.
REQ-016 SHALL keep a pending scoreboard of 2^REG_WIDTH bits; pending[r] = an issued, un-written-back writer of r exists.
REQ-017 SHALL flag hazard when in_valid is high and either source has pending set, unless wb_en is high with wb_addr equal to that source in the same cycle.
- When ZERO_REG=1, register 0 never raises a hazard.
REQ-018 SHALL drive in_ready = (!s2_valid || out_ready) && !hazard; accept = in_valid && in_ready.
REQ-019 SHALL drive rf_rd_addr1 = in_src1, rf_rd_addr2 = in_src2 and rf_stall = !accept, so the register file keeps the S2 address while S2 holds.
REQ-020 SHALL update S2 at each edge as follows:
- accept: load s2_valid=1, plus the src/dst/dst_en fields.
- otherwise, if out_ready: clear s2_valid.
- otherwise: hold.
REQ-021 SHALL drive out_opN = wb_data when wb_en is high and wb_addr equals s2_srcN (bypass); otherwise out_opN = rf_rd_dataN.
- When ZERO_REG=1, out_opN = 0 whenever s2_srcN = 0.
REQ-022 SHALL hold out_op*, out_dst and out_dst_en stable while out_valid && !out_ready, except that bypass data updates when a write-back to the source lands.
REQ-023 SHALL clear pending[wb_addr] on wb_en.
REQ-024 SHALL set pending[in_dst] on accept with in_dst_en, except register 0 when ZERO_REG=1.
REQ-025 SHALL let the set win when set and clear hit the same register in the same cycle.
REQ-026 SHALL ignore a write-back to a non-pending register for scoreboard purposes; it still passes through to rf_*.
REQ-027 SHALL allow in_dst equal to a source (e.g. r3 <- r3 op r1); the hazard check uses pending state before this accept's set.
REQ-028 SHALL, with out_ready tied high and no hazards, accept one instruction per cycle.

Reset
REQ-029 SHALL, while rst is high, force s2_valid=0 and out_valid=0, clear every pending bit, and drive out_dst=0, out_dst_en=0.
REQ-030 SHALL discard an in-flight S2 instruction when rst asserts mid-operation; no pending bit survives.
REQ-031 SHALL keep in_ready low while rst is high.

Verification
REQ-032 Back-to-back: rf holds r1=5, r2=9; issue (src1=1, src2=2) with out_ready=1 -> out_valid next cycle, out_op1=5, out_op2=9.
REQ-033 RAW interlock: issue dst=4; next cycle issue src1=4 -> in_ready=0 until wb_en, wb_addr=4, wb_data=0xA; same cycle in_ready=1, and next cycle out_op1=0xA.
REQ-034 S2 bypass: S2 holds src2=7 with out_ready=0; pulse wb to r7 = 0x3 -> out_op2=0x3 that cycle; after release, out_op2 stays 0x3 from rf.
REQ-035 Zero register: ZERO_REG=1, issue src1=0, dst=0, dst_en=1 -> out_op1=0, pending[0] stays 0, next src1=0 not stalled.
REQ-036 Set/clear collision: wb to r6 in the same cycle an instruction with dst=6 is accepted -> pending[6]=1 afterwards.
REQ-037 Reset mid-flight: out_valid=1, pending[2]=1, assert rst -> out_valid=0, in_ready=0, and after release src=2 is accepted without stall.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: single-stage operand fetch with a register scoreboard.
//
// An instruction issued upstream is accepted into stage S2 when its source
// registers have no outstanding writer. Operands come from an external
// register file with a registered read address. A write-back landing on an
// S2 source is bypassed straight onto the operand outputs.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid / in_ready          upstream issue handshake
//   in_src1, in_src2, in_dst     source / destination register numbers
//   in_dst_en                    issued instruction writes in_dst
//   out_valid / out_ready        downstream handshake
//   out_op1, out_op2             fetched operands
//   out_dst, out_dst_en          destination carried with the instruction
//   wb_en, wb_addr, wb_data      write-back bus
//   rf_rd_addr1/2, rf_stall      register-file read address and address hold
//   rf_rd_data1/2                register-file read data (one cycle after address)
//   rf_wen, rf_wr_addr, rf_wr_data  write-back forwarded to the register file
module operand_fetch #(
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_WIDTH-1:0]  in_src1,
  input  logic [REG_WIDTH-1:0]  in_src2,
  input  logic [REG_WIDTH-1:0]  in_dst,
  input  logic                  in_dst_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [REG_WIDTH-1:0]  out_dst,
  output logic                  out_dst_en,
  input  logic                  wb_en,
  input  logic [REG_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_WIDTH-1:0]  rf_rd_addr1,
  output logic [REG_WIDTH-1:0]  rf_rd_addr2,
  output logic                  rf_stall,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  output logic                  rf_wen,
  output logic [REG_WIDTH-1:0]  rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data
);

  localparam int NUM_REGS = 1 << REG_WIDTH;

  // Scoreboard: one bit per register, set while a writer is in flight.
  logic [NUM_REGS-1:0]   pending_reg;
  logic [NUM_REGS-1:0]   pending_next;

  logic                  s2_valid_reg;
  logic [REG_WIDTH-1:0]  s2_src1_reg;
  logic [REG_WIDTH-1:0]  s2_src2_reg;
  logic [REG_WIDTH-1:0]  s2_dst_reg;
  logic                  s2_dst_en_reg;

  logic                  hazard1;
  logic                  hazard2;
  logic                  hazard;
  logic                  accept;

  // Register 0 is hardwired to zero when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [REG_WIDTH-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  // A write-back arriving this cycle resolves the dependency: the register
  // file captures it at the same edge the reader is accepted, so the reader
  // sees the new value through the registered read path.
  assign hazard1 = pending_reg[in_src1] && !(wb_en && (wb_addr == in_src1))
                   && !is_zero_reg(in_src1);
  assign hazard2 = pending_reg[in_src2] && !(wb_en && (wb_addr == in_src2))
                   && !is_zero_reg(in_src2);
  assign hazard  = in_valid && (hazard1 || hazard2);

  assign in_ready = !rst && (!s2_valid_reg || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Register-file read side: the address is captured only on accept, so the
  // file keeps presenting the S2 instruction's operands while S2 holds.
  assign rf_rd_addr1 = in_src1;
  assign rf_rd_addr2 = in_src2;
  assign rf_stall    = !accept;

  assign rf_wen     = wb_en;
  assign rf_wr_addr = wb_addr;
  assign rf_wr_data = wb_data;

  // Per-register next state. Setting takes priority over clearing so that
  // a new writer issued in the same cycle its predecessor retires keeps the
  // register marked busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
      localparam bit CAN_SET = !((ZERO_REG != 0) && (gi == 0));
      logic set_bit;
      logic clr_bit;
      assign set_bit = CAN_SET && accept && in_dst_en
                       && (in_dst == REG_WIDTH'(gi));
      assign clr_bit = wb_en && (wb_addr == REG_WIDTH'(gi));
      assign pending_next[gi] = set_bit ? 1'b1 :
                                clr_bit ? 1'b0 : pending_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Stage S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_src1_reg   <= '0;
      s2_src2_reg   <= '0;
      s2_dst_reg    <= '0;
      s2_dst_en_reg <= 1'b0;
    end else if (accept) begin
      s2_valid_reg  <= 1'b1;
      s2_src1_reg   <= in_src1;
      s2_src2_reg   <= in_src2;
      s2_dst_reg    <= in_dst;
      s2_dst_en_reg <= in_dst_en;
    end else if (out_ready) begin
      s2_valid_reg  <= 1'b0;
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_dst    = s2_dst_reg;
  assign out_dst_en = s2_dst_en_reg;

  // Operand select: zero register, then live write-back bypass, then file.
  always_comb begin
    out_op1 = rf_rd_data1;
    if (is_zero_reg(s2_src1_reg)) begin
      out_op1 = '0;
    end else if (wb_en && (wb_addr == s2_src1_reg)) begin
      out_op1 = wb_data;
    end
  end

  always_comb begin
    out_op2 = rf_rd_data2;
    if (is_zero_reg(s2_src2_reg)) begin
      out_op2 = '0;
    end else if (wb_en && (wb_addr == s2_src2_reg)) begin
      out_op2 = wb_data;
    end
  end

endmodule
